// File: rtl/tmpl_scan_ctrl.sv
// Template scan controller: walks a TMPL_DIM x TMPL_DIM grid of cell centres, fetches
// template and camera pixels, and accumulates their SAD. Optional macro: TMPL_BINARIZE_EN.
module tmpl_scan_ctrl #(
  parameter int HALVING  = 4,
  parameter int TMPL_DIM = 16,
  parameter int LAT      = 3
`ifdef TMPL_BINARIZE_EN
  ,
  parameter logic [9:0] THRESH = 10'd128
`endif
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iSTART,
  input  logic [12:0] iX0,
  input  logic [12:0] iY0,
  output logic [12:0] oX,
  output logic [12:0] oY,
  input  logic [9:0]  iTVAL,
  output logic        oPIX_REQ,
  output logic [12:0] oPIX_X,
  output logic [12:0] oPIX_Y,
  input  logic        iPIX_VAL,
  input  logic [9:0]  iPIX,
  output logic        oBUSY,
  output logic [17:0] oSAD,
  output logic        oDONE
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CMP, S_DONE} state_t;

  localparam int IDX_W  = (TMPL_DIM > 1) ? $clog2(TMPL_DIM) : 1;
  localparam int WAIT_W = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [IDX_W-1:0]  IDX_MAX   = IDX_W'(TMPL_DIM - 1);
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(LAT - 1);
  localparam logic [12:0]       HALF_CELL = 13'(1 << (HALVING - 1));

  function automatic logic [12:0] centre(input logic [IDX_W-1:0] idx);
    return (13'(idx) << HALVING) + HALF_CELL;
  endfunction

  state_t            r_state;
  logic [12:0]       r_x0, r_y0;
  logic [IDX_W-1:0]  r_col, r_row;
  logic [WAIT_W-1:0] r_wait;
  logic              r_pend;
  logic [9:0]        r_pix;
  logic [17:0]       r_acc;
  logic [12:0]       r_x, r_y, r_pix_x, r_pix_y;
  logic              r_pix_req, r_busy, r_done;
  logic [17:0]       r_sad;

  logic [IDX_W-1:0]  w_ncol, w_nrow;
  logic [12:0]       w_nx, w_ny;
  logic              w_last, w_fire;
  logic [9:0]        w_pix_sel, w_pix_eff, w_diff;
  logic [17:0]       w_acc_next;

  assign w_last = (r_col == IDX_MAX) && (r_row == IDX_MAX);
  assign w_ncol = (r_col == IDX_MAX) ? '0 : r_col + 1'b1;
  assign w_nrow = (r_col != IDX_MAX) ? r_row :
                  (r_row == IDX_MAX) ? '0 : r_row + 1'b1;
  assign w_nx   = centre(w_ncol);
  assign w_ny   = centre(w_nrow);

  // A pixel arriving in the same cycle as CMP is used directly instead of via the latch.
  assign w_fire    = (r_state == S_CMP) && (r_pend || iPIX_VAL);
  assign w_pix_sel = r_pend ? r_pix : iPIX;
`ifdef TMPL_BINARIZE_EN
  assign w_pix_eff = (w_pix_sel >= THRESH) ? 10'd255 : 10'd0;
`else
  assign w_pix_eff = w_pix_sel;
`endif
  assign w_diff     = (iTVAL >= w_pix_eff) ? (iTVAL - w_pix_eff) : (w_pix_eff - iTVAL);
  assign w_acc_next = r_acc + 18'(w_diff);

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state   <= S_IDLE;
      r_x0      <= '0;
      r_y0      <= '0;
      r_col     <= '0;
      r_row     <= '0;
      r_wait    <= '0;
      r_pend    <= 1'b0;
      r_pix     <= '0;
      r_acc     <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_pix_x   <= '0;
      r_pix_y   <= '0;
      r_pix_req <= 1'b0;
      r_busy    <= 1'b0;
      r_sad     <= '0;
      r_done    <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low here; a later non-blocking write in the case wins.
      r_pix_req <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (iSTART) begin
            r_x0      <= iX0;
            r_y0      <= iY0;
            r_acc     <= '0;
            r_col     <= '0;
            r_row     <= '0;
            r_pend    <= 1'b0;
            r_x       <= HALF_CELL;
            r_y       <= HALF_CELL;
            r_pix_x   <= iX0 + HALF_CELL;
            r_pix_y   <= iY0 + HALF_CELL;
            r_pix_req <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_wait  <= WAIT_INIT;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (iPIX_VAL && !r_pend) begin
            r_pix  <= iPIX;
            r_pend <= 1'b1;
          end
          if (r_wait == '0) r_state <= S_CMP;
          else              r_wait  <= r_wait - 1'b1;
        end
        S_CMP: begin
          if (w_fire) begin
            r_acc  <= w_acc_next;
            r_pend <= 1'b0;
            if (w_last) begin
              r_sad   <= w_acc_next;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_col     <= w_ncol;
              r_row     <= w_nrow;
              r_x       <= w_nx;
              r_y       <= w_ny;
              r_pix_x   <= r_x0 + w_nx;
              r_pix_y   <= r_y0 + w_ny;
              r_pix_req <= 1'b1;
              r_state   <= S_ISSUE;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign oX       = r_x;
  assign oY       = r_y;
  assign oPIX_X   = r_pix_x;
  assign oPIX_Y   = r_pix_y;
  assign oPIX_REQ = r_pix_req;
  assign oBUSY    = r_busy;
  assign oSAD     = r_sad;
  assign oDONE    = r_done;

endmodule

// File: doc/tmpl_scan_ctrl.md
Name: tmpl_scan_ctrl

Overview:
- Sequences a full 16x16 template comparison against the camera frame.
- Walks the template cells in raster order and drives cell-centre coordinates into the template lookup (3-cycle pipelined ROM).
- Requests the matching camera pixel at a latched frame offset and accumulates the sum of absolute differences (SAD).
- Sits between the camera frame buffer read port and the template lookup; reports one SAD per start command.

Parameters:
- HALVING, 4: log2 of cell size in pixels; must match the template lookup's shift.
- TMPL_DIM, 16: cells per row and per column; grid is TMPL_DIM*TMPL_DIM = 256 cells.
- LAT, 3: template lookup latency in clock edges.
- THRESH, 10'd128: binarisation threshold, used only with the optional feature.

Ports:
- iCLK  in  1  system clock
- iRST  in  1  asynchronous, active-high reset
- iSTART  in  1  start a scan; sampled only in IDLE
- iX0  in  13  frame X offset of template origin; latched on start
- iY0  in  13  frame Y offset of template origin; latched on start
- oX  out  13  template-relative X to lookup
- oY  out  13  template-relative Y to lookup
- iTVAL  in  10  template value from lookup
- oPIX_REQ  out  1  one-cycle camera pixel request
- oPIX_X  out  13  absolute frame X of requested pixel
- oPIX_Y  out  13  absolute frame Y of requested pixel
- iPIX_VAL  in  1  camera pixel valid
- iPIX  in  10  camera grey pixel
- oBUSY  out  1  scan in progress
- oSAD  out  18  accumulated SAD; held between scans
- oDONE  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, any state, including mid-scan): state IDLE; all outputs 0; cell counter, accumulator and pixel latch cleared.
- FSM states: IDLE, ISSUE, WAIT, CMP, DONE.
- IDLE:
  - On iSTART=1: latch iX0/iY0, clear accumulator and cell index, go to ISSUE.
  - oBUSY=1 from the next cycle until DONE ends.
- ISSUE (1 cycle):
  - Drive oX = (col<<HALVING) + (1<<(HALVING-1)) and oY = (row<<HALVING) + (1<<(HALVING-1)).
  - Drive oPIX_X = X0+oX and oPIX_Y = Y0+oY, each 13-bit, wrapping mod 8192.
  - Assert oPIX_REQ for this cycle only. Go to WAIT.
- Coordinate hold: oX, oY, oPIX_X and oPIX_Y are held stable from ISSUE through CMP.
- WAIT (exactly LAT cycles): down-counter, then CMP.
- Pixel acceptance:
  - The first iPIX_VAL seen in WAIT or CMP latches iPIX and sets a pending flag.
  - Later iPIX_VAL pulses for the same cell are ignored.
  - iPIX_VAL is ignored in IDLE, ISSUE and DONE.
- CMP:
  - Waits until the pending flag is set or iPIX_VAL=1 (same-cycle pixel is used directly).
  - On that edge: accumulator += |iTVAL - pix|, computed in 10-bit unsigned with no sign wrap.
  - Clears pending, advances col; on col wrap, advances row.
  - If the cell just processed was 255: go to DONE; otherwise go to ISSUE.
- Timing with iPIX_VAL held high: 5 edges per cell. If iSTART is sampled at edge k, DONE is entered at edge k+1280.
- DONE (1 cycle): oDONE=1; oSAD = accumulator, held until the next start. Then IDLE; oBUSY=0.
- Accumulator width: 18 bits; worst case 256*1023 = 261888, so no overflow and no saturation needed.
- iSTART while busy: ignored. iSTART held high: a new scan starts on the edge after DONE.

Optional Feature:
- Macro: TMPL_BINARIZE_EN.
- Defined: the camera pixel is replaced by 255 if pix >= THRESH, else 0, before the difference is taken.
- Undefined: raw 10-bit grey pixel is used.
- Port list is identical either way.

Test Plan:
- Production template (25 cells at 0, 231 at 255), iPIX=255 constant, iPIX_VAL tied high, start at edge k -> oDONE pulses after edge k+1280; oSAD=6375.
- Same setup, iPIX=0 -> oSAD=58905. With TMPL_BINARIZE_EN and iPIX=100 -> oSAD=58905; with iPIX=128 -> oSAD=6375.
- Camera model returns exactly the template value for each requested coordinate, iX0=100, iY0=50 -> oSAD=0.
  - First request has oPIX_X=108, oPIX_Y=58.
  - Last request has oPIX_X=348, oPIX_Y=298.
- Camera model with random 1-8 cycle iPIX_VAL delay plus duplicate pulses -> exactly 256 oPIX_REQ pulses; oSAD equals the reference-model SAD; no double accumulation.
- iRST asserted at cell 100, mid-WAIT -> oBUSY, oDONE, oSAD and oPIX_REQ go 0 immediately. New iSTART -> complete scan with correct SAD. iSTART pulses during a busy scan -> no effect.
- iX0=8190, iY0=0 -> first oPIX_X=6 (wrap mod 8192); scan completes normally.
